resp_checker: RTL and testbench

Synthesizable response checker for exhaustive gate-level and transistor-level checks. It is the receiving end of the stimulus stream that applies every input combination to a small combinational DUT. For each applied vector it waits a settle interval, then samples the DUT output and compares it against a golden truth table. It accumulates a mismatch count, a first-failure record, a coverage bitmap and an optional signature. It sits beside the DUT, fed by the vector source that drives the DUT inputs.

---
 rtl/resp_check_pkg.sv | 20 ++
 rtl/resp_misr.sv | 37 +++
 rtl/resp_checker.sv | 161 ++++++++++++++++
 tb/tb_resp_checker.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resp_check_pkg.sv
// Shared types and constants for the exhaustive response checker.
package resp_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int              SIG_W     = 16;
    localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
    localparam logic [SIG_W-1:0] MISR_SEED = 16'hFFFF;

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                   input logic             din);
        return {sig[SIG_W-2:0], 1'b0} ^ ((sig[SIG_W-1] ^ din) ? MISR_POLY : '0);
    endfunction

endpackage

// File: rtl/resp_misr.sv
// Response signature register: seeds on reset or seed_i, shifts one dut_r bit per enable.
// Only built when RESP_CHECK_MISR_EN is defined.
`ifdef RESP_CHECK_MISR_EN
module resp_misr
    import resp_check_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             seed_i,
    input  logic             en_i,
    input  logic             din_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (seed_i) begin
            sig_d = MISR_SEED;
        end else if (en_i) begin
            sig_d = misr_step(sig_q, din_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule
`endif

// File: rtl/resp_checker.sv
// Receives vectors applied to a combinational DUT, samples dut_r after a settle delay
// and scores it against GOLDEN. Optional signature via RESP_CHECK_MISR_EN.
//
// state  | meaning
// IDLE   | ready for the next vector
// SETTLE | waiting for DUT output to settle
// SAMPLE | dut_r scored at the closing edge
// DONE   | run finished, results held until clear/rst
module resp_checker
    import resp_check_pkg::*;
#(
    parameter int                 N_IN       = 5,
    parameter logic [2**N_IN-1:0] GOLDEN     = '0,
    parameter int                 SETTLE_CYC = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               vec_valid_i,
    input  logic [N_IN-1:0]    vec_in_i,
    input  logic               vec_last_i,
    output logic               vec_ready_o,
    input  logic               dut_r_i,
    output logic               done_o,
    output logic               pass_o,
    output logic [N_IN:0]      err_cnt_o,
    output logic               first_err_vld_o,
    output logic [N_IN-1:0]    first_err_vec_o,
    output logic [2**N_IN-1:0] cov_o,
    output logic [SIG_W-1:0]   sig_o
);

    localparam int N_VEC = 2**N_IN;
    localparam int CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    state_e             state_q, state_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_IN:0]      err_q, err_d;
    logic               fe_vld_q, fe_vld_d;
    logic [N_IN-1:0]    fe_vec_q, fe_vec_d;
    logic [N_VEC-1:0]   cov_q, cov_d;
    logic               pass_q, pass_d;
    logic               mismatch;

    // X/Z on dut_r counts as a mismatch in simulation
    assign mismatch = (dut_r_i !== GOLDEN[vec_q]);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        fe_vld_d    = fe_vld_q;
        fe_vec_d    = fe_vec_q;
        cov_d       = cov_q;
        pass_d      = pass_q;
        vec_ready_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                vec_ready_o = 1'b1;
                if (vec_valid_i) begin
                    vec_d   = vec_in_i;
                    last_d  = vec_last_i;
                    cnt_d   = CNT_W'(SETTLE_CYC);
                    state_d = (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fe_vld_q) begin
                        fe_vld_d = 1'b1;
                        fe_vec_d = vec_q;
                    end
                end
                cov_d[vec_q] = 1'b1;
                if (last_q) begin
                    pass_d  = (err_d == '0) && (&cov_d);
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear_i) begin
            state_d  = ST_IDLE;
            vec_d    = '0;
            last_d   = 1'b0;
            cnt_d    = '0;
            err_d    = '0;
            fe_vld_d = 1'b0;
            fe_vec_d = '0;
            cov_d    = '0;
            pass_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            err_q    <= '0;
            fe_vld_q <= 1'b0;
            fe_vec_q <= '0;
            cov_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            fe_vld_q <= fe_vld_d;
            fe_vec_q <= fe_vec_d;
            cov_q    <= cov_d;
            pass_q   <= pass_d;
        end
    end

    assign done_o          = (state_q == ST_DONE);
    assign pass_o          = pass_q;
    assign err_cnt_o       = err_q;
    assign first_err_vld_o = fe_vld_q;
    assign first_err_vec_o = fe_vec_q;
    assign cov_o           = cov_q;

`ifdef RESP_CHECK_MISR_EN
    logic misr_en;
    assign misr_en = (state_q == ST_SAMPLE) && !clear_i;

    resp_misr u_misr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .seed_i (clear_i),
        .en_i   (misr_en),
        .din_i  (dut_r_i),
        .sig_o  (sig_o)
    );
`else
    assign sig_o = '0;
`endif

endmodule

// File: tb/tb_resp_checker.sv
// Self-checking bench for resp_checker: randomized runs scored against a truth-table model.
module tb_resp_checker;

    localparam int          SETTLE = 3;
    localparam logic [31:0] GOLD   = 32'h6996_9669;
`ifdef RESP_CHECK_MISR_EN
    localparam logic [15:0] SIG_RST = 16'hFFFF;
`else
    localparam logic [15:0] SIG_RST = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst, clear, vec_valid, vec_last, dut_r;
    logic [4:0]  vec_in;
    logic        vec_ready, done, pass, first_err_vld;
    logic [5:0]  err_cnt;
    logic [4:0]  first_err_vec;
    logic [31:0] cov;
    logic [15:0] sig;

    int total = 0;
    int bad   = 0;

    logic [31:0] gold_tbl;
    int          m_err;
    logic        m_fe_vld;
    logic [4:0]  m_fe_vec;
    logic [31:0] m_cov;
    logic [15:0] m_sig;

    resp_checker #(.N_IN(5), .GOLDEN(GOLD), .SETTLE_CYC(SETTLE)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .clear_i         (clear),
        .vec_valid_i     (vec_valid),
        .vec_in_i        (vec_in),
        .vec_last_i      (vec_last),
        .vec_ready_o     (vec_ready),
        .dut_r_i         (dut_r),
        .done_o          (done),
        .pass_o          (pass),
        .err_cnt_o       (err_cnt),
        .first_err_vld_o (first_err_vld),
        .first_err_vec_o (first_err_vec),
        .cov_o           (cov),
        .sig_o           (sig)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_err    = 0;
        m_fe_vld = 1'b0;
        m_fe_vec = '0;
        m_cov    = '0;
        m_sig    = SIG_RST;
    endtask

    task automatic model_apply(input logic [4:0] v, input logic r);
        if (r !== gold_tbl[v]) begin
            if (m_err < 63) m_err++;
            if (!m_fe_vld) begin
                m_fe_vld = 1'b1;
                m_fe_vec = v;
            end
        end
        m_cov[v] = 1'b1;
`ifdef RESP_CHECK_MISR_EN
        m_sig = {m_sig[14:0], 1'b0} ^ ((m_sig[15] ^ r) ? 16'h1021 : 16'h0000);
`endif
    endtask

    function automatic logic [61:0] obs_pack();
        return {done, pass, err_cnt, first_err_vld, first_err_vec, cov, sig};
    endfunction

    function automatic logic [61:0] exp_pack(input logic d);
        logic p;
        p = d && (m_err == 0) && (m_cov == 32'hFFFF_FFFF);
        return {d, p, 6'(m_err), m_fe_vld, m_fe_vec, m_cov, m_sig};
    endfunction

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    // dut_r is wrong for the first two cycles after acceptance, right from the third on
    task automatic send_vec(input logic [4:0] v, input logic last, input logic r);
        int n;
        int low;
        int exp_low;
        n = 0;
        while (vec_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (vec_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_wait: vec_ready=%b required 1", vec_ready);
        end
        vec_valid = 1'b1;
        vec_in    = v;
        vec_last  = last;
        dut_r     = ~r;
        low       = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                vec_valid = 1'b0;
                vec_in    = 5'($urandom);
                vec_last  = 1'($urandom);
            end
            if (vec_ready !== 1'b1) low++;
            if (k == 5) dut_r = 1'($urandom);
            else        dut_r = (k >= 3) ? r : ~r;
        end
        model_apply(v, r);
        exp_low = last ? 5 : 4;
        total++;
        if (low != exp_low) begin
            bad++;
            $display("FAIL ready_low vec=%0d: low cycles=%0d required %0d", v, low, exp_low);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; vec_valid = 1'b0; vec_in = '0; vec_last = 1'b0; dut_r = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (vec_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b required 1", vec_ready);
        end
        total++;
        if (obs_pack() !== exp_pack(1'b0)) begin
            bad++;
            $display("FAIL reset_values: got %h required %h", obs_pack(), exp_pack(1'b0));
        end
    endtask

    task automatic test_full_run();
        logic [61:0] held;
        pulse_clear();
        for (int v = 0; v < 32; v++) send_vec(5'(v), v == 31, gold_tbl[v]);
        total++;
        if (obs_pack() !== exp_pack(1'b1)) begin
            bad++;
            $display("FAIL full_run: got %h required %h", obs_pack(), exp_pack(1'b1));
        end
        total++;
        if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 6'd0 || cov !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL full_run_flags: done=%b pass=%b err=%0d cov=%h required 1 1 0 ffffffff",
                     done, pass, err_cnt, cov);
        end
        held = obs_pack();
        for (int k = 0; k < 6; k++) begin
            vec_valid = 1'b1;
            vec_in    = 5'($urandom);
            vec_last  = 1'($urandom);
            dut_r     = 1'($urandom);
            @(negedge clk);
        end
        vec_valid = 1'b0;
        total++;
        if (obs_pack() !== held || vec_ready !== 1'b0) begin
            bad++;
            $display("FAIL done_hold: got %h ready=%b required %h ready=0", obs_pack(), vec_ready, held);
        end
    endtask

    task automatic test_errors();
        pulse_clear();
        for (int v = 0; v < 32; v++) send_vec(5'(v), v == 31, gold_tbl[v] ^ (v == 22 || v == 31));
        total++;
        if (obs_pack() !== exp_pack(1'b1)) begin
            bad++;
            $display("FAIL errors_run: got %h required %h", obs_pack(), exp_pack(1'b1));
        end
        total++;
        if (err_cnt !== 6'd2 || first_err_vld !== 1'b1 || first_err_vec !== 5'd22 || pass !== 1'b0) begin
            bad++;
            $display("FAIL errors_flags: err=%0d fe_vld=%b fe_vec=%0d pass=%b required 2 1 22 0",
                     err_cnt, first_err_vld, first_err_vec, pass);
        end
    endtask

    task automatic test_missing_cov();
        pulse_clear();
        for (int v = 0; v < 31; v++) send_vec(5'(v), v == 30, gold_tbl[v]);
        total++;
        if (done !== 1'b1 || pass !== 1'b0 || cov !== 32'h7FFF_FFFF || err_cnt !== 6'd0) begin
            bad++;
            $display("FAIL missing_cov: done=%b pass=%b cov=%h err=%0d required 1 0 7fffffff 0",
                     done, pass, cov, err_cnt);
        end
    endtask

    task automatic test_rst_mid_settle();
        pulse_clear();
        for (int v = 0; v < 7; v++) send_vec(5'(v), 1'b0, gold_tbl[v] ^ (v == 3));
        vec_valid = 1'b1; vec_in = 5'd7; vec_last = 1'b0; dut_r = gold_tbl[7];
        @(negedge clk);
        vec_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        total++;
        if (obs_pack() !== exp_pack(1'b0) || cov[7] !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_settle: got %h required %h", obs_pack(), exp_pack(1'b0));
        end
        total++;
        if (vec_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_ready_next: vec_ready=%b required 1", vec_ready);
        end
        send_vec(5'd9, 1'b1, gold_tbl[9]);
        total++;
        if (cov !== 32'h0000_0200 || done !== 1'b1 || pass !== 1'b0 || obs_pack() !== exp_pack(1'b1)) begin
            bad++;
            $display("FAIL rst_after_vec: got %h required %h", obs_pack(), exp_pack(1'b1));
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            int len;
            pulse_clear();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                logic [4:0] v;
                v = 5'($urandom);
                send_vec(v, i == len - 1, gold_tbl[v] ^ ($urandom_range(0, 3) == 0));
            end
            total++;
            if (obs_pack() !== exp_pack(1'b1)) begin
                bad++;
                $display("FAIL random_run%0d: got %h required %h", round, obs_pack(), exp_pack(1'b1));
            end
        end
    endtask

    task automatic test_saturate();
        pulse_clear();
        for (int i = 0; i < 70; i++) begin
            logic [4:0] v;
            v = 5'($urandom);
            send_vec(v, i == 69, ~gold_tbl[v]);
        end
        total++;
        if (err_cnt !== 6'h3F || obs_pack() !== exp_pack(1'b1)) begin
            bad++;
            $display("FAIL saturate: err=%0d got %h required err=63 %h", err_cnt, obs_pack(), exp_pack(1'b1));
        end
    endtask

    task automatic test_clear();
        pulse_clear();
        total++;
        if (obs_pack() !== exp_pack(1'b0) || sig !== SIG_RST || done !== 1'b0 || vec_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_after_done: got %h ready=%b required %h ready=1",
                     obs_pack(), vec_ready, exp_pack(1'b0));
        end
        vec_valid = 1'b1; vec_in = 5'd12; vec_last = 1'b1; dut_r = ~gold_tbl[12];
        @(negedge clk);
        vec_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (obs_pack() !== exp_pack(1'b0) || vec_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_mid_settle: got %h ready=%b required %h ready=1",
                     obs_pack(), vec_ready, exp_pack(1'b0));
        end
    endtask

    initial begin
        gold_tbl = GOLD;
        test_reset();
        test_full_run();
        test_clear();
        test_errors();
        test_missing_cov();
        test_rst_mid_settle();
        test_random();
        test_saturate();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
